// File: rtl/comp_job_ctrl.sv
// comp_job_ctrl: job sequencer in front of the LZRW1 compressor core.
// Accepts one job of STRINGSIZE bytes from the host as BEAT_BYTES-wide beats.
// Before each job it holds the core in reset. It then streams the beats into
// the core, waits for Done under a timeout and presents a result/status
// record to the host. This block is the only driver of the core's reset,
// valid and CurByte inputs.
module comp_job_ctrl #(
    parameter int STRINGSIZE   = 350,
    parameter int BEAT_BYTES   = 16,
    parameter int RESET_CYCLES = 2,
    parameter int DONE_TIMEOUT = 4096
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    job_start,
    output logic                    job_busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*BEAT_BYTES-1:0] in_data,
    output logic                    comp_reset,
    output logic                    comp_valid,
    output logic [8*BEAT_BYTES-1:0] comp_curbyte,
    input  logic                    comp_done,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic                    res_timeout,
    output logic [15:0]             res_cycles
);

    // Job geometry: the final beat only carries LAST_BYTES valid bytes.
    localparam int DATA_W     = 8 * BEAT_BYTES;
    localparam int BEATS      = (STRINGSIZE + BEAT_BYTES - 1) / BEAT_BYTES;
    localparam int LAST_BYTES = STRINGSIZE - BEAT_BYTES * (BEATS - 1);
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RST_W      = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_FEED,
        ST_WAIT,
        ST_RESULT
    } state_t;

    state_t              state_reg,        state_next;
    logic [RST_W-1:0]    rst_cnt_reg,      rst_cnt_next;
    logic [BEAT_W-1:0]   beat_cnt_reg,     beat_cnt_next;
    logic [15:0]         timer_reg,        timer_next;
    logic                comp_valid_reg,   comp_valid_next;
    logic [DATA_W-1:0]   comp_curbyte_reg, comp_curbyte_next;
    logic                res_timeout_reg,  res_timeout_next;
    logic [15:0]         res_cycles_reg,   res_cycles_next;

    logic                beat_accept;
    logic                last_beat;
    logic                clr_last;
    logic                wait_expired;
    logic [DATA_W-1:0]   keep_mask;

    // Handshake and counter terminal conditions.
    assign beat_accept  = in_valid && (state_reg == ST_FEED);
    assign last_beat    = (beat_cnt_reg == BEAT_W'(BEATS - 1));
    assign clr_last     = (rst_cnt_reg == RST_W'(RESET_CYCLES - 1));
    assign wait_expired = (timer_reg == 16'(DONE_TIMEOUT - 1));

    // Byte lanes beyond the end of the job are zeroed on the final beat so the
    // core never sees stale host data past STRINGSIZE.
    genvar gi;
    generate
        for (gi = 0; gi < BEAT_BYTES; gi++) begin : g_lane
            localparam bit PAD_LANE = (gi >= LAST_BYTES);
            assign keep_mask[8*gi +: 8] = (PAD_LANE && last_beat) ? 8'h00 : 8'hFF;
        end
    endgenerate

    // Next-state, counter and output-register logic; every value holds by default.
    always_comb begin
        state_next        = state_reg;
        rst_cnt_next      = rst_cnt_reg;
        beat_cnt_next     = beat_cnt_reg;
        timer_next        = timer_reg;
        comp_valid_next   = 1'b0;
        comp_curbyte_next = comp_curbyte_reg;
        res_timeout_next  = res_timeout_reg;
        res_cycles_next   = res_cycles_reg;

        case (state_reg)
            ST_IDLE: begin
                if (job_start) begin
                    state_next   = ST_CLR;
                    rst_cnt_next = '0;
                end
            end

            ST_CLR: begin
                if (clr_last) begin
                    state_next    = ST_FEED;
                    beat_cnt_next = '0;
                end else begin
                    rst_cnt_next = rst_cnt_reg + RST_W'(1);
                end
            end

            ST_FEED: begin
                if (beat_accept) begin
                    comp_valid_next   = 1'b1;
                    comp_curbyte_next = in_data & keep_mask;
                    if (last_beat) begin
                        state_next = ST_WAIT;
                        timer_next = '0;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
                    end
                end
            end

            ST_WAIT: begin
                timer_next = timer_reg + 16'd1;
                // Done wins over the timeout when both land on the same cycle.
                if (comp_done) begin
                    state_next       = ST_RESULT;
                    res_timeout_next = 1'b0;
                    res_cycles_next  = timer_reg;
                end else if (wait_expired) begin
                    state_next       = ST_RESULT;
                    res_timeout_next = 1'b1;
                    res_cycles_next  = 16'(DONE_TIMEOUT);
                end
            end

            ST_RESULT: begin
                if (res_ready) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any job and clears every output.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            rst_cnt_reg      <= '0;
            beat_cnt_reg     <= '0;
            timer_reg        <= '0;
            comp_valid_reg   <= 1'b0;
            comp_curbyte_reg <= '0;
            res_timeout_reg  <= 1'b0;
            res_cycles_reg   <= '0;
        end else begin
            state_reg        <= state_next;
            rst_cnt_reg      <= rst_cnt_next;
            beat_cnt_reg     <= beat_cnt_next;
            timer_reg        <= timer_next;
            comp_valid_reg   <= comp_valid_next;
            comp_curbyte_reg <= comp_curbyte_next;
            res_timeout_reg  <= res_timeout_next;
            res_cycles_reg   <= res_cycles_next;
        end
    end

    // Status outputs decode straight from the state register.
    assign job_busy     = (state_reg != ST_IDLE);
    assign in_ready     = (state_reg == ST_FEED);
    assign comp_reset   = (state_reg == ST_CLR);
    assign res_valid    = (state_reg == ST_RESULT);
    assign comp_valid   = comp_valid_reg;
    assign comp_curbyte = comp_curbyte_reg;
    assign res_timeout  = res_timeout_reg;
    assign res_cycles   = res_cycles_reg;

endmodule
